seq_pattern_gen: RTL

//   Serial pattern transmitter: loads a programmable bit pattern and shifts it out MSB-first,
//   one bit per clock, on a single-bit serial line. Supports N repetitions with idle gaps.
//   It is the stimulus/transmit end of the serial-bit interface consumed by the sequence

---
 rtl/seq_pattern_gen_pkg.sv | 20 ++
 rtl/seq_pattern_shifter.sv | 39 +++
 rtl/seq_pattern_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Holds the FSM state encoding, default widths and the frame length clamp.
package seq_pattern_gen_pkg;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        PAR,
        GAP
    } state_t;

    // Frame lengths above the pattern width send the whole pattern
    function automatic int clamp_len(input int l, input int w);
        return (l > w) ? w : l;
    endfunction

endpackage

// File: rtl/seq_pattern_shifter.sv
// MSB-first shift register with a remaining-bit counter.
// A load consumes the head bit; the head of sr is always the next bit to send.
module seq_pattern_shifter
    import seq_pattern_gen_pkg::*;
#(
    parameter int W  = PAT_W,
    parameter int LW = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    output logic          head,
    output logic          last_bit
);

    logic [W-1:0]  sr;
    logic [LW-1:0] cnt;

    // Load an MSB-aligned frame (first bit already taken) or advance one bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data << 1;
            cnt <= len - LW'(1);
        end else if (shift) begin
            sr  <= sr << 1;
            cnt <= cnt - LW'(1);
        end
    end

    assign head     = sr[W-1];
    assign last_bit = (cnt == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeated MSB-first frames with idle gaps.
// Define SEQ_PATTERN_GEN_PARITY_EN to append an even parity bit per frame.
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int W     = PAT_W,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       pattern,
    input  logic [$clog2(W):0] len,
    input  logic [REP_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    localparam int LW = $clog2(W) + 1;

    state_t           state;
    logic [W-1:0]     pat_q;
    logic [W-1:0]     src_pat;
    logic [W-1:0]     aligned;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    len_c;
    logic [LW-1:0]    src_len;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             par;
    logic             head;
    logic             last_bit;
    logic             shift;
    logic             more;
    logic             to_par;
    logic             frame_end;
    logic             reload;

    assign len_c   = LW'(clamp_len(int'(len), W));
    assign src_pat = (state == IDLE) ? pattern : pat_q;
    assign src_len = (state == IDLE) ? len_c : len_q;
    assign aligned = src_pat << (LW'(W) - src_len);
    assign shift   = (state == SEND) && x_valid && !last_bit;
    assign more    = (rep_cnt > REP_W'(1)) && (len_q != '0);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    assign to_par    = (state == SEND) && x_valid && last_bit;
    assign frame_end = (state == PAR) || ((state == SEND) && !x_valid);
`else
    assign to_par    = 1'b0;
    assign frame_end = (state == SEND) && (!x_valid || last_bit);
`endif

    // A frame's first bit goes out from start, a gapless repeat or gap expiry
    assign reload = ((state == IDLE) && start && (len_c != '0))
                  || (frame_end && more && (gap_q == '0))
                  || ((state == GAP) && (gap_cnt == GAP_W'(1)));

    seq_pattern_shifter #(
        .W  (W),
        .LW (LW)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (reload),
        .shift    (shift),
        .data     (aligned),
        .len      (src_len),
        .head     (head),
        .last_bit (last_bit)
    );

    // Frame sequencing FSM with registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            par     <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            rep_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        len_q   <= len_c;
                        gap_q   <= gap;
                        rep_cnt <= (reps == '0) ? REP_W'(1) : reps;
                        busy    <= 1'b1;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (shift) begin
                        x   <= head;
                        par <= par ^ head;
                    end
                    if (to_par) begin
                        x     <= par;
                        state <= PAR;
                    end
                end
                PAR: begin
                end
                GAP: begin
                    if (gap_cnt != GAP_W'(1))
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase

            if (frame_end) begin
                if (more) begin
                    rep_cnt <= rep_cnt - REP_W'(1);
                    if (gap_q != '0) begin
                        state   <= GAP;
                        gap_cnt <= gap_q;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                    end
                end else begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                end
            end

            if (reload) begin
                x       <= aligned[W-1];
                x_valid <= 1'b1;
                par     <= aligned[W-1];
                state   <= SEND;
            end
        end
    end

endmodule
